// File: rtl/tlp_fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the transaction-layer TLP FIFO.
// Grants are taken at packet boundaries and held until the last beat, so TLPs
// never interleave. Over-length packets are truncated at MAX_BEATS and the
// remainder is drained without being written.
module tlp_fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_wdata,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 len_err,
  input  logic                 err_clr
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            len_err_nxt;

  logic [PW-1:0]   gidx;
  logic [PW-1:0]   win;
  logic            accept;

  // State, grant, round-robin pointer, beat counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= PW'(NREQ - 1);
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      len_err <= len_err_nxt;
    end
  end

  assign busy = (state != IDLE);

  // Next-state logic plus the combinational write/ready path for the granted lane
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    len_err_nxt = err_clr ? 1'b0 : len_err;
    req_ready   = '0;
    fifo_wr     = 1'b0;
    fifo_wdata  = '0;
    accept      = 1'b0;
    gidx        = '0;
    win         = '0;

    // one-hot grant to index
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) gidx = PW'(i);
    end

    // round-robin search starting just after the last winner; the loop runs
    // downwards so the nearest requester in scan order is the one that sticks
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (req_valid[PW'((int'(ptr) + k) % int'(NREQ))]) begin
        win = PW'((int'(ptr) + k) % int'(NREQ));
      end
    end

    if (|grant) fifo_wdata = req_data[int'(gidx)*DW +: DW];

    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = XFER;
        end
      end

      XFER: begin
        accept          = req_valid[gidx] & ~fifo_full;
        fifo_wr         = accept;
        req_ready[gidx] = accept;
        if (accept) begin
          cnt_nxt = CW'(cnt + 1'b1);
          if (req_last[gidx]) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = gidx;
          end else if (cnt == CW'(MAX_BEATS - 1)) begin
            len_err_nxt = 1'b1;
            state_nxt   = DRAIN;
          end
        end
      end

      DRAIN: begin
        req_ready[gidx] = req_valid[gidx];
        if (req_valid[gidx] && req_last[gidx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = gidx;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule
